arith_fa_reg: RTL and testbench
===============================

// Module: arith_fa_reg
// PURPOSE
//  Registered full adder built from per-bit full-adder cells (sum/carry cell
//  functions as read from a Liberty arithmetic cell library).
//  Operand bits x, y and carry-in cin are summed combinationally.
//  Sum and carry-out are captured in flops on the clock edge.
//  Sum output has a tri-state enable so a bench can check the undriven (Z)
//  condition. Used as the top of the Liberty-arith frontend regression.
// PARAMETERS
//  WIDTH  1  operand width in bits; ripple chain of WIDTH one-bit cells (>=1)
// PORTS
//  clk      in   1      single clock, all state updates on posedge
//  rst      in   1      synchronous, active-high reset
//  x        in   WIDTH  operand A
//  y        in   WIDTH  operand B
//  cin      in   1      carry into bit 0
//  oe       in   1      sum output enable; 0 -> regA driven Z
//  regA     out  WIDTH  registered sum (tri-state)
//  regcout  out  1      registered carry out of MSB cell (always driven)
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is synchronous and active-high.
//  - Cell i: s[i] = x[i]^y[i]^c[i]; c[i+1] = x[i]&y[i] | c[i]&(x[i]^y[i]).
//    c[0] = cin. Carry out = c[WIDTH]. Equivalent: {c[WIDTH],s} = x+y+cin
//    computed at WIDTH+1 bits, no truncation of carry.
//  - Pure combinational cells; no latches. Outputs depend only on flops.
//  - Posedge clk, rst=1: sum_q <= 0, cout_q <= 0 (rst has priority over data).
//  - Posedge clk, rst=0: sum_q <= s, cout_q <= c[WIDTH].
//  - Latency: exactly 1 cycle from x/y/cin sampled to regA/regcout.
//  - regA = oe ? sum_q : {WIDTH{1'bz}}; oe is combinational to the pad, with no
//    register. Toggling oe does not disturb sum_q.
//  - regcout = cout_q regardless of oe.
//  - Reset value: regA = 0 when oe=1 (Z when oe=0); regcout = 0.
//  - Reset asserted mid-stream: next edge clears both flops. The first result
//    after deassert reflects inputs sampled on that first non-reset edge.
//  - Wrap-around: all-ones + all-ones + 1 gives sum all-ones, carry 1.
//  - X/Z on inputs propagates per gate semantics. No special handling.
// TESTING
//  - WIDTH=1 exhaustive sweep of {cin,y,x}=0..7, oe=1, one step per clk ->
//    each cycle regA=x^y^cin and regcout=majority(x,y,cin); 3'b111 -> 1/1,
//    3'b011 -> 0/1, 3'b001 -> 1/0.
//  - Reset: rst=1 for 2 cycles with x=y=cin=1 -> regA=0, regcout=0.
//    Deassert -> next edge regA=1, regcout=1.
//  - oe=0 with any inputs -> regA===1'bz every cycle, regcout still tracks the
//    carry. Raise oe -> regA shows the held sum_q immediately.
//  - WIDTH=4: x=4'hF, y=4'h1, cin=0 -> regA=4'h0, regcout=1.
//    x=4'hF, y=4'hF, cin=1 -> regA=4'hF, regcout=1.
//  - Latency check: change inputs mid-cycle -> outputs change only at the next
//    posedge, never combinationally.
//  - Reset mid-operation (rst pulsed 1 cycle during the sweep) -> that edge
//    gives 0/0. The following edge resumes the correct sum.

Source files
------------

// File: rtl/arith_fa_reg.sv
// Registered ripple-carry adder built from one-bit full-adder cells.
// Sum and carry-out are flopped; the sum pad has a combinational tri-state enable.
module arith_fa_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic             oe,
   output logic [WIDTH-1:0] regA,
   output logic             regcout
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] sum_q;
   logic             cout_d;
   logic             cout_q;

   // Ripple chain: each cell feeds its carry into the next higher bit.
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < WIDTH; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   always_comb begin
      sum_d  = s;
      cout_d = c[WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   // Enable goes straight to the pad so raising oe shows the held sum at once.
   assign regA    = oe ? sum_q : {WIDTH{1'bz}};
   assign regcout = cout_q;

endmodule

// File: tb/tb_arith_fa_reg.sv
// Bench for arith_fa_reg: a 4-bit and a 1-bit instance share clock, reset and
// output enable; results are compared against an arithmetic reference model.
module tb_arith_fa_reg;

   logic       clk;
   logic       rst;
   logic       oe;
   logic [3:0] x4;
   logic [3:0] y4;
   logic       cin4;
   logic       x1;
   logic       y1;
   logic       cin1;
   wire  [3:0] regA4;
   wire        regcout4;
   wire        regA1;
   wire        regcout1;

   int errors = 0;
   int checks = 0;

   // Reference model: value held in the DUT flops after the last edge.
   logic [3:0] m_sum4;
   logic       m_cout4;
   logic       m_sum1;
   logic       m_cout1;

   typedef struct {
      logic       rst;
      logic       oe;
      logic [3:0] x;
      logic [3:0] y;
      logic       cin;
      logic [3:0] s;
      logic       co;
      logic       s1;
      logic       co1;
   } vec_t;

   vec_t tbl[10];

   arith_fa_reg #(.WIDTH(4)) u_dut4 (
      .clk     (clk),
      .rst     (rst),
      .x       (x4),
      .y       (y4),
      .cin     (cin4),
      .oe      (oe),
      .regA    (regA4),
      .regcout (regcout4)
   );

   arith_fa_reg #(.WIDTH(1)) u_dut1 (
      .clk     (clk),
      .rst     (rst),
      .x       (x1),
      .y       (y1),
      .cin     (cin1),
      .oe      (oe),
      .regA    (regA1),
      .regcout (regcout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, clock it in, update the model, sample at edge+1.
   task automatic tick(input logic r, input logic o,
                       input logic [3:0] a4, input logic [3:0] b4, input logic c4,
                       input logic a1, input logic b1, input logic c1);
      logic [4:0] t4;
      logic [1:0] t1;
      rst  = r;
      oe   = o;
      x4   = a4;
      y4   = b4;
      cin4 = c4;
      x1   = a1;
      y1   = b1;
      cin1 = c1;
      @(posedge clk);
      t4 = {1'b0, a4} + {1'b0, b4} + {4'b0, c4};
      t1 = {1'b0, a1} + {1'b0, b1} + {1'b0, c1};
      if (r) begin
         m_sum4  = 4'h0;
         m_cout4 = 1'b0;
         m_sum1  = 1'b0;
         m_cout1 = 1'b0;
      end else begin
         {m_cout4, m_sum4} = t4;
         {m_cout1, m_sum1} = t1;
      end
      #1;
   endtask

   task automatic check_outputs(input string tag);
      logic [3:0] e4;
      logic [3:0] e1;
      e4 = oe ? m_sum4 : 4'bzzzz;
      e1 = oe ? {3'b000, m_sum1} : {3'b000, 1'bz};
      chk({tag, "_sum4"}, regA4, e4);
      chk({tag, "_cout4"}, {3'b000, regcout4}, {3'b000, m_cout4});
      chk({tag, "_sum1"}, {3'b000, regA1}, e1);
      chk({tag, "_cout1"}, {3'b000, regcout1}, {3'b000, m_cout1});
   endtask

   initial begin
      logic [2:0] v;
      logic       es;
      logic       ec;

      // rst, oe, x, y, cin, exp sum4, exp cout4, exp sum1, exp cout1
      tbl[0] = '{1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 1'b1, 4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1};
      tbl[6] = '{1'b0, 1'b1, 4'h5, 4'hA, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1};
      tbl[7] = '{1'b0, 1'b1, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};
      tbl[8] = '{1'b0, 1'b1, 4'h7, 4'h1, 1'b1, 4'h9, 1'b0, 1'b1, 1'b1};
      tbl[9] = '{1'b0, 1'b1, 4'h3, 4'h4, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1};

      rst = 1'b1; oe = 1'b1;
      x4 = '0; y4 = '0; cin4 = 1'b0;
      x1 = 1'b0; y1 = 1'b0; cin1 = 1'b0;
      m_sum4 = '0; m_cout4 = 1'b0; m_sum1 = 1'b0; m_cout1 = 1'b0;

      // Table: reset held two cycles with all-ones inputs, then known sums.
      for (int i = 0; i < 10; i++) begin
         tick(tbl[i].rst, tbl[i].oe, tbl[i].x, tbl[i].y, tbl[i].cin, 1'b1, 1'b1, 1'b1);
         chk("tbl_sum4", regA4, tbl[i].s);
         chk("tbl_cout4", {3'b000, regcout4}, {3'b000, tbl[i].co});
         chk("tbl_sum1", {3'b000, regA1}, {3'b000, tbl[i].s1});
         chk("tbl_cout1", {3'b000, regcout1}, {3'b000, tbl[i].co1});
      end

      // Exhaustive one-bit sweep, {cin,y,x} = 0..7, against xor/majority.
      for (int i = 0; i < 8; i++) begin
         v = i[2:0];
         tick(1'b0, 1'b1, 4'($urandom), 4'($urandom), 1'($urandom), v[0], v[1], v[2]);
         es = v[0] ^ v[1] ^ v[2];
         ec = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
         chk("sweep_sum1", {3'b000, regA1}, {3'b000, es});
         chk("sweep_cout1", {3'b000, regcout1}, {3'b000, ec});
         check_outputs("sweep");
      end

      // Sweep again with a one-cycle reset pulse in the middle.
      for (int i = 0; i < 8; i++) begin
         v = i[2:0];
         tick(i == 4, 1'b1, 4'hF, 4'hF, 1'b1, v[0], v[1], v[2]);
         if (i == 4) begin
            chk("midrst_sum1", {3'b000, regA1}, 4'h0);
            chk("midrst_cout1", {3'b000, regcout1}, 4'h0);
            chk("midrst_sum4", regA4, 4'h0);
         end
         check_outputs("midrst");
      end

      // Latency: inputs changing mid-cycle must not reach the outputs.
      tick(1'b0, 1'b1, 4'h3, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0);
      x4 = 4'hF; y4 = 4'hF; cin4 = 1'b1; x1 = 1'b1; y1 = 1'b1;
      #3;
      chk("latency_sum4", regA4, 4'h7);
      chk("latency_cout4", {3'b000, regcout4}, 4'h0);
      chk("latency_sum1", {3'b000, regA1}, 4'h1);
      @(posedge clk);
      #1;
      chk("latency_next_sum4", regA4, 4'hF);
      chk("latency_next_cout4", {3'b000, regcout4}, 4'h1);
      m_sum4 = 4'hF; m_cout4 = 1'b1; m_sum1 = 1'b0; m_cout1 = 1'b1;

      // Output disabled: sum pad floats, carry keeps tracking.
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 4'($urandom_range(8, 15)), 4'($urandom_range(8, 15)), 1'($urandom),
              1'b1, 1'b1, 1'($urandom));
         check_outputs("oe_off");
      end
      oe = 1'b1;
      #1;
      chk("oe_raise_sum4", regA4, m_sum4);
      chk("oe_raise_sum1", {3'b000, regA1}, {3'b000, m_sum1});

      // Random traffic with occasional reset and output-enable toggling.
      for (int i = 0; i < 300; i++) begin
         tick($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
              4'($urandom), 4'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
         check_outputs("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
